mod_n_updown_counter: RTL and testbench
=======================================

MOD_N_UPDOWN_COUNTER -- requirements
Module: mod_n_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4: width of count and load data.
REQ-002 Parameter MODULUS, default 13: count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at range ends, 1 = hold at range ends.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-006 en  input  1  count enable.
REQ-007 up_dn  input  1  direction: 1 = up, 0 = down.
REQ-008 load  input  1  parallel load strobe.
REQ-009 d  input  WIDTH  parallel load value.
REQ-010 count  output  WIDTH  current count, registered.
REQ-011 tc  output  1  terminal count, combinational, for cascading.
REQ-012 wrap  output  1  registered one-cycle pulse: a wrap (or saturation hold) occurred on the last edge.
REQ-013 load_err  output  1  registered one-cycle pulse: last load value was out of range.

Function
REQ-014 Each rising edge SHALL apply exactly one action, priority: rst=0 > load=1 > en=1 > hold.
REQ-015 Load SHALL set count to d when d <= MODULUS-1, regardless of en and up_dn.
REQ-016 Load with d >= MODULUS SHALL set count to MODULUS-1 and pulse load_err for one cycle.
REQ-017 Loads of legal values, counting and holding SHALL leave load_err at 0 on the following cycle.
REQ-018 With en=1, load=0, up_dn=1 and count < MODULUS-1, count SHALL increment by 1.
REQ-019 With en=1, load=0, up_dn=0 and count > 0, count SHALL decrement by 1.
REQ-020 Up at MODULUS-1: SATURATE=0 gives count=0; SATURATE=1 holds count at MODULUS-1.
REQ-021 Down at 0: SATURATE=0 gives count=MODULUS-1; SATURATE=1 holds count at 0.
REQ-022 wrap SHALL pulse high for one cycle after any edge that executed REQ-020 or REQ-021; it is 0 otherwise.
REQ-023 tc SHALL equal en AND NOT load AND (up_dn ? count==MODULUS-1 : count==0), with no register delay.
REQ-024 With en=0 and load=0, count SHALL hold, and wrap and load_err SHALL be 0 on the next cycle.
REQ-025 A direction change SHALL take effect on the same edge where it is sampled, with no bubble cycle.
REQ-026 Arithmetic SHALL be WIDTH bits with no intermediate overflow; when MODULUS=2**WIDTH, wrap SHALL match natural binary roll-over.
REQ-027 count SHALL never leave 0..MODULUS-1 under any input sequence after reset.

Reset
REQ-028 rst=0 at a rising edge SHALL set count=0, wrap=0 and load_err=0, overriding load and en.
REQ-029 Assertion of rst in the middle of counting or on a load cycle SHALL discard that operation.
REQ-030 Counting SHALL resume on the first edge at which rst=1.
REQ-031 Before the first reset edge, output values are undefined and SHALL NOT be checked.

Verification (WIDTH=4, MODULUS=13 unless noted)
REQ-032 Up-wrap scenario: rst pulse, then en=1, up_dn=1 for 14 edges.
- count steps 0..12 then returns to 0.
- tc=1 while count=12.
- wrap pulses exactly once, the cycle after 12 -> 0.
REQ-033 Illegal load scenario: load=1 with d=13, then d=15.
- Each load gives count=12 with a load_err pulse.
- A following load with d=5 gives count=5 and load_err=0.
REQ-034 Down and direction change scenario: load 2, then en=1, up_dn=0 for 4 edges.
- count follows 1, 0, 12, 11; wrap pulses after 0 -> 12.
- Set up_dn=1 for one edge: count=12.
REQ-035 Saturate scenario (SATURATE=1): load 12, en=1, up_dn=1 for 3 edges.
- count stays at 12 and wrap pulses each edge.
- Then up_dn=0 from count 1 for 3 edges: count follows 0, 0, 0.
REQ-036 Priority and reset scenario:
- load=1 with en=1 and d=7: count=7, no increment.
- rst=0 together with load=1 and d=9: count=0.
- en=0 for 5 edges: count holds with tc=0.
REQ-037 Full-range scenario (MODULUS=16): count up from 15 -> 0 with wrap pulse; count down from 0 -> 15.

Source files
------------

// File: rtl/mod_n_updown_counter.sv
// rtl/mod_n_updown_counter.sv - modulo-N up/down counter with load, saturate option and terminal count
module mod_n_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 13,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    // Top of range held in WIDTH bits so MODULUS = 2**WIDTH never needs an extra bit.
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic at_max;
    logic at_zero;

    assign at_max  = (count == MAXV);
    assign at_zero = (count == ZERO);
    assign tc      = en & ~load & (up_dn ? at_max : at_zero);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count    <= ZERO;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (d > MAXV) begin
                    count    <= MAXV;
                    load_err <= 1'b1;
                end else begin
                    count <= d;
                end
            end else if (en) begin
                if (up_dn) begin
                    if (at_max) begin
                        wrap  <= 1'b1;
                        count <= (SATURATE != 0) ? MAXV : ZERO;
                    end else begin
                        count <= count + WIDTH'(1);
                    end
                end else begin
                    if (at_zero) begin
                        wrap  <= 1'b1;
                        count <= (SATURATE != 0) ? ZERO : MAXV;
                    end else begin
                        count <= count - WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// tb/tb_mod_n_updown_counter.sv - directed self-checking bench for mod_n_updown_counter
module tb_mod_n_updown_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] d;

    logic [3:0] count_a, count_b, count_c;
    logic       tc_a, tc_b, tc_c;
    logic       wrap_a, wrap_b, wrap_c;
    logic       lerr_a, lerr_b, lerr_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // a: default wrap counter, b: saturating, c: full binary range
    mod_n_updown_counter #(.WIDTH(4), .MODULUS(13), .SATURATE(0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .d(d),
        .count(count_a), .tc(tc_a), .wrap(wrap_a), .load_err(lerr_a));

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(13), .SATURATE(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .d(d),
        .count(count_b), .tc(tc_b), .wrap(wrap_b), .load_err(lerr_b));

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_c (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .d(d),
        .count(count_c), .tc(tc_c), .wrap(wrap_c), .load_err(lerr_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b1; d = 4'd9;
        tick();
        chk("reset_count_a", count_a, 0);
        chk("reset_wrap_a", wrap_a, 0);
        chk("reset_lerr_a", lerr_a, 0);
        chk("reset_count_b", count_b, 0);
        chk("reset_count_c", count_c, 0);

        // up-wrap over 14 edges
        rst = 1'b1; load = 1'b0; en = 1'b1; up_dn = 1'b1;
        #1;
        chk("upwrap_tc_at0", tc_a, 0);
        for (int i = 1; i <= 14; i++) begin
            tick();
            chk($sformatf("upwrap_count_%0d", i), count_a, i % 13);
            chk($sformatf("upwrap_wrap_%0d", i), wrap_a, (i == 13) ? 1 : 0);
            chk($sformatf("upwrap_tc_%0d", i), tc_a, (i == 12) ? 1 : 0);
        end
        chk("sat_upwrap_count_b", count_b, 12);
        chk("sat_upwrap_wrap_b", wrap_b, 1);
        chk("full_up_count_c", count_c, 14);

        // illegal loads
        en = 1'b0; load = 1'b1; d = 4'd13;
        tick();
        chk("load13_count_a", count_a, 12);
        chk("load13_lerr_a", lerr_a, 1);
        chk("load13_count_c", count_c, 13);
        chk("load13_lerr_c", lerr_c, 0);
        d = 4'd15;
        tick();
        chk("load15_count_a", count_a, 12);
        chk("load15_lerr_a", lerr_a, 1);
        chk("load15_count_c", count_c, 15);
        d = 4'd5;
        tick();
        chk("load5_count_a", count_a, 5);
        chk("load5_lerr_a", lerr_a, 0);
        load = 1'b0;
        tick();
        chk("hold_count_a", count_a, 5);
        chk("hold_lerr_a", lerr_a, 0);
        chk("hold_wrap_a", wrap_a, 0);

        // down count and direction change
        load = 1'b1; d = 4'd2;
        tick();
        chk("load2_count_a", count_a, 2);
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
        tick();
        chk("down1_count_a", count_a, 1);
        tick();
        chk("down2_count_a", count_a, 0);
        chk("down2_tc_a", tc_a, 1);
        chk("down2_count_b", count_b, 0);
        tick();
        chk("down3_count_a", count_a, 12);
        chk("down3_wrap_a", wrap_a, 1);
        chk("down3_count_b", count_b, 0);
        chk("down3_wrap_b", wrap_b, 1);
        chk("down3_count_c", count_c, 15);
        chk("down3_wrap_c", wrap_c, 1);
        tick();
        chk("down4_count_a", count_a, 11);
        chk("down4_wrap_a", wrap_a, 0);
        up_dn = 1'b1;
        tick();
        chk("dirchg_count_a", count_a, 12);
        chk("dirchg_tc_a", tc_a, 1);
        chk("dirchg_count_c", count_c, 15);

        // saturation at top
        en = 1'b0; load = 1'b1; d = 4'd12;
        tick();
        chk("sat_load_count_b", count_b, 12);
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("sat_up_count_%0d", i), count_b, 12);
            chk($sformatf("sat_up_wrap_%0d", i), wrap_b, 1);
        end
        chk("sat_up_count_a", count_a, 2);

        // saturation at bottom
        load = 1'b1; d = 4'd1;
        tick();
        chk("sat_load1_count_b", count_b, 1);
        load = 1'b0; up_dn = 1'b0;
        tick();
        chk("sat_dn0_count_b", count_b, 0);
        chk("sat_dn0_wrap_b", wrap_b, 0);
        tick();
        chk("sat_dn1_count_b", count_b, 0);
        chk("sat_dn1_wrap_b", wrap_b, 1);
        tick();
        chk("sat_dn2_count_b", count_b, 0);
        chk("sat_dn2_wrap_b", wrap_b, 1);
        chk("full_dn_count_c", count_c, 14);

        // full-range roll-over up
        load = 1'b1; d = 4'd15; up_dn = 1'b1;
        #1;
        chk("full_tc_under_load_c", tc_c, 0);
        tick();
        chk("full_load_count_c", count_c, 15);
        load = 1'b0;
        #1;
        chk("full_tc_c", tc_c, 1);
        tick();
        chk("full_roll_count_c", count_c, 0);
        chk("full_roll_wrap_c", wrap_c, 1);

        // priority: load beats enable
        load = 1'b1; en = 1'b1; d = 4'd7;
        tick();
        chk("prio_load_count_a", count_a, 7);
        tick();
        chk("prio_load2_count_a", count_a, 7);

        // reset beats load, including an illegal one
        d = 4'd15;
        tick();
        chk("pre_rst_lerr_a", lerr_a, 1);
        rst = 1'b0; d = 4'd9;
        tick();
        chk("rst_load_count_a", count_a, 0);
        chk("rst_load_lerr_a", lerr_a, 0);
        chk("rst_load_wrap_a", wrap_a, 0);

        rst = 1'b1; load = 1'b0; en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("idle_count_%0d", i), count_a, 0);
            chk($sformatf("idle_tc_%0d", i), tc_a, 0);
        end
        en = 1'b1; up_dn = 1'b1;
        tick();
        chk("resume_count_a", count_a, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
